rvv_backend_vrf_wb: RTL and testbench

Write-back queue that sits directly upstream of the vector register file storage. It collects byte-masked register writes from `NUM_WP` retire write ports into an in-order queue. It drains up to `NUM_WP` entries per cycle into the per-register byte-enable (`wen`) and data (`wdata`) arrays that the VRF flops sample. Same-register writes with disjoint byte enables are merged in one cycle; overlapping writes are serialised in age order, so the last write always wins.

---
 rtl/rvv_backend_vrf_wb.sv | 175 +++++++++++++++++
 tb/tb_rvv_backend_vrf_wb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_vrf_wb.sv
// rvv_backend_vrf_wb
//   Write-back queue in front of the vector register file storage. Byte-masked
//   register writes from NUM_WP retire ports are collected into an in-order
//   circular queue. Up to NUM_WP of the oldest entries are drained each cycle
//   onto per-register byte-enable/data arrays sampled by the VRF flops.
//   Same-register writes with disjoint byte enables drain together; an
//   overlapping write stalls behind the older one, so the last write wins.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   wr_valid/ready   : per-port handshake; port 0 is oldest within a cycle
//   wr_addr/be/data  : destination register, byte enables, write data
//   wen, wdata       : per-register byte enables / data to the VRF storage
//   vrf_wr_pending   : register i has at least one queued write
//   wb_empty         : queue holds no valid entry
module rvv_backend_vrf_wb #(
  parameter int unsigned NUM_WP  = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_VRF = 32,
  parameter int unsigned VLEN    = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WP-1:0]                 wr_valid,
  output logic [NUM_WP-1:0]                 wr_ready,
  input  logic [NUM_WP-1:0][4:0]            wr_addr,
  input  logic [NUM_WP-1:0][VLEN/8-1:0]     wr_be,
  input  logic [NUM_WP-1:0][VLEN-1:0]       wr_data,
  output logic [NUM_VRF-1:0][VLEN/8-1:0]    wen,
  output logic [NUM_VRF-1:0][VLEN-1:0]      wdata,
  output logic [NUM_VRF-1:0]                vrf_wr_pending,
  output logic                              wb_empty
);

  localparam int unsigned VLENB = VLEN / 8;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Queue storage
  logic [DEPTH-1:0]            q_valid;
  logic [DEPTH-1:0][4:0]       q_addr;
  logic [DEPTH-1:0][VLENB-1:0] q_be;
  logic [DEPTH-1:0][VLEN-1:0]  q_data;
  ptr_t                        head;
  ptr_t                        tail;
  cnt_t                        count;

  // Per-cycle control
  cnt_t                        free;
  logic [NUM_WP-1:0]           acc;
  logic [NUM_WP-1:0][PW-1:0]   slot;
  cnt_t                        n_acc;
  logic [NUM_WP-1:0][PW-1:0]   cidx;
  logic [NUM_WP-1:0]           drain;
  cnt_t                        n_drn;

  // Free slots are taken from the registered count only, so entries vacated
  // by this cycle's drain are not reused until the next cycle.
  assign free = cnt_t'(DEPTH) - count;

  always_comb begin
    wr_ready = '0;
    for (int unsigned p = 0; p < NUM_WP; p++) begin
      wr_ready[p] = !rst && (cnt_t'(p) < free);
    end
  end

  assign acc = wr_valid & wr_ready;

  // Accepted ports are packed into consecutive slots from tail, so a skipped
  // port leaves no hole in the queue.
  always_comb begin
    n_acc = '0;
    slot  = '0;
    for (int unsigned p = 0; p < NUM_WP; p++) begin
      slot[p] = tail + n_acc[PW-1:0];
      if (acc[p]) begin
        n_acc = n_acc + 1'b1;
      end
    end
  end

  // Drain the longest age-ordered prefix of the NUM_WP oldest entries in
  // which no entry overlaps an older one on both register and byte lanes.
  always_comb begin
    logic go;
    logic ok;
    go    = 1'b1;
    ok    = 1'b0;
    n_drn = '0;
    drain = '0;
    cidx  = '0;
    for (int unsigned k = 0; k < NUM_WP; k++) begin
      cidx[k] = head + ptr_t'(k);
      ok      = go && q_valid[cidx[k]];
      for (int unsigned m = 0; m < k; m++) begin
        if ((q_addr[cidx[m]] == q_addr[cidx[k]]) &&
            (|(q_be[cidx[m]] & q_be[cidx[k]]))) begin
          ok = 1'b0;
        end
      end
      drain[k] = ok;
      go       = ok;
      if (ok) begin
        n_drn = n_drn + 1'b1;
      end
    end
  end

  // Drained entries never share a byte lane on the same register, so each
  // enabled byte has exactly one source.
  always_comb begin
    wen   = '0;
    wdata = '0;
    for (int unsigned k = 0; k < NUM_WP; k++) begin
      if (drain[k]) begin
        wen[q_addr[cidx[k]]] = wen[q_addr[cidx[k]]] | q_be[cidx[k]];
        for (int unsigned j = 0; j < VLENB; j++) begin
          if (q_be[cidx[k]][j]) begin
            wdata[q_addr[cidx[k]]][8*j +: 8] = q_data[cidx[k]][8*j +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    vrf_wr_pending = '0;
    for (int unsigned d = 0; d < DEPTH; d++) begin
      if (q_valid[d]) begin
        vrf_wr_pending[q_addr[d]] = 1'b1;
      end
    end
  end

  assign wb_empty = ~|q_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WP; k++) begin
        if (drain[k]) begin
          q_valid[cidx[k]] <= 1'b0;
        end
      end
      for (int unsigned p = 0; p < NUM_WP; p++) begin
        if (acc[p]) begin
          q_valid[slot[p]] <= 1'b1;
        end
      end
      head  <= head + n_drn[PW-1:0];
      tail  <= tail + n_acc[PW-1:0];
      count <= count + n_acc - n_drn;
    end
  end

  // Payload is qualified by q_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_WP; p++) begin
      if (acc[p]) begin
        q_addr[slot[p]] <= wr_addr[p];
        q_be[slot[p]]   <= wr_be[p];
        q_data[slot[p]] <= wr_data[p];
      end
    end
  end

endmodule

// File: tb/tb_rvv_backend_vrf_wb.sv
// Testbench for rvv_backend_vrf_wb: directed scenarios plus randomized traffic
// against a queue-based reference model and a program-order register image.
module tb_rvv_backend_vrf_wb;

  localparam int NW    = 2;
  localparam int DEPTH = 4;
  localparam int NVRF  = 32;
  localparam int VLEN  = 128;
  localparam int VLENB = VLEN / 8;

  logic clk;
  logic rst;

  logic [NW-1:0]                  wr_valid;
  logic [NW-1:0]                  wr_ready;
  logic [NW-1:0][4:0]             wr_addr;
  logic [NW-1:0][VLENB-1:0]       wr_be;
  logic [NW-1:0][VLEN-1:0]        wr_data;
  logic [NVRF-1:0][VLENB-1:0]     wen;
  logic [NVRF-1:0][VLEN-1:0]      wdata;
  logic [NVRF-1:0]                vrf_wr_pending;
  logic                           wb_empty;

  // Second instance with DEPTH == NUM_WP so the completely-full state is reachable.
  logic [NW-1:0]                  v2;
  logic [NW-1:0]                  rdy2;
  logic [NW-1:0][4:0]             a2;
  logic [NW-1:0][VLENB-1:0]       be2;
  logic [NW-1:0][VLEN-1:0]        dat2;
  logic [NVRF-1:0][VLENB-1:0]     wen2;
  logic [NVRF-1:0][VLEN-1:0]      wdata2;
  logic [NVRF-1:0]                pend2;
  logic                           empty2;

  rvv_backend_vrf_wb #(.NUM_WP(NW), .DEPTH(DEPTH), .NUM_VRF(NVRF), .VLEN(VLEN)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .wen(wen), .wdata(wdata),
    .vrf_wr_pending(vrf_wr_pending), .wb_empty(wb_empty)
  );

  rvv_backend_vrf_wb #(.NUM_WP(NW), .DEPTH(2), .NUM_VRF(NVRF), .VLEN(VLEN)) dut_d2 (
    .clk(clk), .rst(rst),
    .wr_valid(v2), .wr_ready(rdy2), .wr_addr(a2), .wr_be(be2),
    .wr_data(dat2), .wen(wen2), .wdata(wdata2),
    .vrf_wr_pending(pend2), .wb_empty(empty2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       addr;
    logic [VLENB-1:0] be;
    logic [VLEN-1:0]  data;
  } ent_t;

  ent_t             mq[$];
  logic [VLEN-1:0]  vrf_model [NVRF];   // image built from DUT wen/wdata
  logic [VLEN-1:0]  golden    [NVRF];   // image built in accept (program) order
  logic [VLENB-1:0] exp_wen   [NVRF];
  logic [VLEN-1:0]  exp_wdata [NVRF];
  logic [NVRF-1:0]  exp_pend;
  int               exp_ndrain;
  int               checks;
  int               failures;

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Oldest-first: take entries while none overlaps an older taken one.
  task automatic model_expect();
    int blocked;
    for (int r = 0; r < NVRF; r++) begin
      exp_wen[r]   = '0;
      exp_wdata[r] = '0;
    end
    exp_pend   = '0;
    exp_ndrain = 0;
    foreach (mq[i]) exp_pend[mq[i].addr] = 1'b1;
    for (int i = 0; i < NW && i < mq.size(); i++) begin
      blocked = 0;
      for (int m = 0; m < i; m++)
        if (mq[m].addr == mq[i].addr && (mq[m].be & mq[i].be) != '0) blocked = 1;
      if (blocked != 0) break;
      exp_wen[mq[i].addr] = exp_wen[mq[i].addr] | mq[i].be;
      for (int j = 0; j < VLENB; j++)
        if (mq[i].be[j]) exp_wdata[mq[i].addr][8*j +: 8] = mq[i].data[8*j +: 8];
      exp_ndrain++;
    end
  endtask

  task automatic check_outputs();
    int free;
    model_expect();
    for (int r = 0; r < NVRF; r++) begin
      check($sformatf("wen[%0d]", r), VLEN'(wen[r]), VLEN'(exp_wen[r]));
      check($sformatf("wdata[%0d]", r), wdata[r], exp_wdata[r]);
      for (int j = 0; j < VLENB; j++)
        if (wen[r][j]) vrf_model[r][8*j +: 8] = wdata[r][8*j +: 8];
    end
    check("pending", VLEN'(vrf_wr_pending), VLEN'(exp_pend));
    check("empty", VLEN'(wb_empty), VLEN'(mq.size() == 0));
    free = DEPTH - mq.size();
    check("ready", VLEN'(wr_ready), VLEN'({free > 1, free > 0}));
  endtask

  task automatic check_mem(input string tag);
    for (int r = 0; r < NVRF; r++)
      check($sformatf("%s[%0d]", tag, r), vrf_model[r], golden[r]);
  endtask

  // One clock: check outputs against the model, drive a request, advance the model.
  task automatic cycle(input logic [NW-1:0] v, input logic [NW-1:0][4:0] a,
                       input logic [NW-1:0][VLENB-1:0] b, input logic [NW-1:0][VLEN-1:0] d);
    logic [NW-1:0] acc;
    int   free;
    ent_t e;
    check_outputs();
    wr_valid = v;
    wr_addr  = a;
    wr_be    = b;
    wr_data  = d;
    free = DEPTH - mq.size();
    for (int p = 0; p < NW; p++) acc[p] = v[p] && (free > p);
    @(posedge clk);
    for (int i = 0; i < exp_ndrain; i++) e = mq.pop_front();
    for (int p = 0; p < NW; p++) begin
      if (acc[p]) begin
        e.addr = a[p];
        e.be   = b[p];
        e.data = d[p];
        mq.push_back(e);
        for (int j = 0; j < VLENB; j++)
          if (b[p][j]) golden[a[p]][8*j +: 8] = d[p][8*j +: 8];
      end
    end
    #1;
    wr_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, '0);
  endtask

  task automatic rand_cycle();
    logic [NW-1:0]            v;
    logic [NW-1:0][4:0]       a;
    logic [NW-1:0][VLENB-1:0] b;
    logic [NW-1:0][VLEN-1:0]  d;
    v = NW'($urandom);
    for (int p = 0; p < NW; p++) begin
      a[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: b[p] = '0;
        1: b[p] = '1;
        2: b[p] = 16'h00FF;
        3: b[p] = 16'hFF00;
        default: b[p] = 16'($urandom);
      endcase
      d[p] = {$urandom, $urandom, $urandom, $urandom};
    end
    cycle(v, a, b, d);
  endtask

  initial begin
    logic [VLEN-1:0] dtmp;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wr_valid = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
    v2 = '0; a2 = '0; be2 = '0; dat2 = '0;
    for (int r = 0; r < NVRF; r++) begin
      vrf_model[r] = '0;
      golden[r]    = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", VLEN'(wr_ready), '0);
    check("rst_ready_d2", VLEN'(rdy2), '0);
    check("rst_empty", VLEN'(wb_empty), VLEN'(1));
    check("rst_pending", VLEN'(vrf_wr_pending), '0);
    for (int r = 0; r < NVRF; r++) check($sformatf("rst_wen[%0d]", r), VLEN'(wen[r]), '0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", VLEN'(wr_ready), VLEN'(2'b11));
    check("post_rst_ready_d2", VLEN'(rdy2), VLEN'(2'b11));

    // Completely full (DEPTH 2): conflicting same-register full writes
    v2   = 2'b11;
    a2   = {5'd1, 5'd1};
    be2  = {16'hFFFF, 16'hFFFF};
    dat2 = {{16{8'hB2}}, {16{8'hA2}}};
    @(posedge clk); #1;
    v2 = '0;
    check("full_ready_d2", VLEN'(rdy2), VLEN'(2'b00));
    check("full_wen_d2", VLEN'(wen2[1]), VLEN'(16'hFFFF));
    check("full_wdata0_d2", wdata2[1], {16{8'hA2}});
    @(posedge clk); #1;
    check("one_free_ready_d2", VLEN'(rdy2), VLEN'(2'b01));
    check("full_wdata1_d2", wdata2[1], {16{8'hB2}});
    @(posedge clk); #1;
    check("drained_empty_d2", VLEN'(empty2), VLEN'(1));

    // Single write
    cycle(2'b01, {5'd0, 5'd3}, {16'h0, 16'hFFFF}, {128'h0, {16{8'hA5}}});
    check("single_wen3", VLEN'(wen[3]), VLEN'(16'hFFFF));
    check("single_wdata3", wdata[3], {16{8'hA5}});
    check("single_pend3", VLEN'(vrf_wr_pending[3]), VLEN'(1));
    idle(1);
    check("single_empty", VLEN'(wb_empty), VLEN'(1));
    check("single_pend3_clr", VLEN'(vrf_wr_pending[3]), '0);

    // Merge of disjoint byte enables
    cycle(2'b11, {5'd5, 5'd5}, {16'hFF00, 16'h00FF}, {{16{8'h22}}, {16{8'h11}}});
    check("merge_wen5", VLEN'(wen[5]), VLEN'(16'hFFFF));
    check("merge_wdata5", wdata[5], {{8{8'h22}}, {8{8'h11}}});
    idle(1);

    // Overlapping writes serialise, last write wins
    cycle(2'b11, {5'd7, 5'd7}, {16'h0003, 16'h000F}, {{16{8'hBB}}, {16{8'hAA}}});
    check("ovl_wen7_a", VLEN'(wen[7]), VLEN'(16'h000F));
    check("ovl_wdata7_a", wdata[7], {{12{8'h00}}, {4{8'hAA}}});
    idle(1);
    check("ovl_wen7_b", VLEN'(wen[7]), VLEN'(16'h0003));
    check("ovl_wdata7_b", wdata[7], {{14{8'h00}}, {2{8'hBB}}});
    idle(1);
    check("ovl_vrf7", VLEN'(vrf_model[7][31:0]), VLEN'(32'hAAAA_BBBB));

    // Backpressure with conflicting traffic, then randomized traffic
    for (int i = 0; i < 6; i++) begin
      dtmp = {$urandom, $urandom, $urandom, $urandom};
      cycle(2'b11, {5'd12, 5'd12}, {16'hFFFF, 16'hFFFF}, {~dtmp, dtmp});
      if (i >= 1) check("bp_ready", VLEN'(wr_ready), VLEN'(2'b01));
    end
    for (int i = 0; i < 400; i++) rand_cycle();
    idle(8);
    check_mem("mem");

    // Mid-operation reset with three queued entries
    cycle(2'b11, {5'd9, 5'd9}, {16'hFFFF, 16'hFFFF}, {{16{8'h99}}, {16{8'h88}}});
    cycle(2'b11, {5'd9, 5'd9}, {16'hFFFF, 16'hFFFF}, {{16{8'h77}}, {16{8'h66}}});
    check("pre_rst_ready", VLEN'(wr_ready), VLEN'(2'b01));
    check("pre_rst_wen9", VLEN'(wen[9]), VLEN'(16'hFFFF));
    #2;
    rst = 1'b1;
    #1;
    for (int r = 0; r < NVRF; r++) check($sformatf("mid_rst_wen[%0d]", r), VLEN'(wen[r]), '0);
    check("mid_rst_empty", VLEN'(wb_empty), VLEN'(1));
    check("mid_rst_pending", VLEN'(vrf_wr_pending), '0);
    check("mid_rst_ready", VLEN'(wr_ready), '0);
    mq.delete();
    for (int r = 0; r < NVRF; r++) golden[r] = vrf_model[r];
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    idle(2);

    // Sparse ports: only port 1 valid
    dtmp = {$urandom, $urandom, $urandom, $urandom};
    cycle(2'b10, {5'd31, 5'd0}, {16'h8000, 16'h0}, {dtmp, 128'h0});
    check("sparse_wen31", VLEN'(wen[31]), VLEN'(16'h8000));
    check("sparse_wdata31", wdata[31], {dtmp[127:120], 120'h0});
    idle(4);
    for (int i = 0; i < 100; i++) rand_cycle();
    idle(8);
    check_mem("mem_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
